// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered pins, 11-bit framing,
// E0/F0 prefix folding, and a show-ahead FIFO of tagged scan codes.
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 4,
  parameter bit PARITY_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] code_byte,
  output logic       code_ext,
  output logic       code_break,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow
);
  localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, nxt;
  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FCW-1:0]   fcnt;
  logic             filt, filt_d, fall;
  logic [TW-1:0]    tcnt;
  logic             timeout;
  logic [2:0]       bit_cnt;
  logic [7:0]       sh;
  logic             par, ext, brk;
  logic             stop_fall, bad_stop, bad_par, acc, wr;
  logic [AW:0]      wptr, rptr;
  logic [9:0]       mem [FIFO_DEPTH];
  logic             empty, full, pop, push;

  // Idle-high synchronisers so a reset never fabricates a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'b1111;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt   <= '0;
      filt   <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      filt_d <= filt;
      if (clk_s2 != filt) begin
        if (fcnt == FCW'(FILTER_LEN - 1)) begin
          filt <= clk_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall    = filt_d & ~filt;
  assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // FSM: next state
  always_comb begin
    nxt = state;
    if (timeout) begin
      nxt = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:    if (!dat_s2) nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) nxt = PARITY;
        PARITY:  nxt = STOP;
        STOP:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // FSM: frame evaluation outputs
  always_comb begin
    stop_fall  = (state == STOP) && fall;
    bad_stop   = stop_fall && !dat_s2;
    bad_par    = stop_fall && dat_s2 && PARITY_EN && !(^{sh, par});
    acc        = stop_fall && dat_s2 && !bad_par;
    wr         = acc && (sh != 8'hE0) && (sh != 8'hF0);
    err_frame  = bad_stop || timeout;
    err_parity = bad_par;
    overflow   = wr && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sh      <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
      ext     <= 1'b0;
      brk     <= 1'b0;
    end else begin
      if (state == IDLE || fall) tcnt <= '0;
      else if (!timeout)         tcnt <= tcnt + 1'b1;

      if (fall) begin
        if (state == IDLE) bit_cnt <= '0;
        if (state == DATA) begin
          sh      <= {dat_s2, sh[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == PARITY) par <= dat_s2;
      end

      // Prefixes accumulate until a final byte or any abort consumes them
      if (timeout || bad_stop || bad_par) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (acc) begin
        if (sh == 8'hE0)      ext <= 1'b1;
        else if (sh == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && code_ready;
  assign push  = wr && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= {brk, ext, sh};
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign code_valid                       = !empty;
  assign {code_break, code_ext, code_byte} = mem[rptr[AW-1:0]];
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Randomized + directed bench: stimulus pushes expected codes/events into queues,
// a separate monitor pops and compares whenever the receiver presents them.
module tb_ps2_scan_rx;
  localparam int FL = 4, TO = 2000, FD = 4, HALF = 100;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1, code_ready = 1'b1;
  logic       code_valid, code_ext, code_break, err_parity, err_frame, overflow;
  logic [7:0] code_byte;

  int checks = 0, failures = 0;
  int cyc_cnt = 0, last_fall = 0;
  logic [9:0] exp_q[$];
  int         exp_evt[$];   // 1 parity, 2 frame, 3 overflow
  bit         m_ext = 0, m_brk = 0;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_valid(code_valid), .code_ready(code_ready), .code_byte(code_byte),
    .code_ext(code_ext), .code_break(code_break), .err_parity(err_parity),
    .err_frame(err_frame), .overflow(overflow));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: frame rules applied directly to the byte-level view
  task automatic model(input logic [7:0] b, input bit p, input bit s);
    if (!s) begin
      exp_evt.push_back(2); m_ext = 0; m_brk = 0;
    end else if ((^{b, p}) != 1'b1) begin
      exp_evt.push_back(1); m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (exp_q.size() >= FD) exp_evt.push_back(3);
      else exp_q.push_back({m_brk, m_ext, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic glitch();
    ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input bit glt);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glt) begin cyc(40); glitch(); cyc(HALF - 43); end
      else cyc(HALF);
      ps2_clk = 1'b0; last_fall = cyc_cnt;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit p, input bit s, input bit glt);
    model(b, p, s);
    send_bits({s, p, b, 1'b0}, 11, glt);
    ps2_data = 1'b1;
    cyc(50);
  endtask

  task automatic good(input logic [7:0] b);
    frame(b, ~^b, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_parity || err_frame || overflow) begin
        int ev;
        ev = err_parity ? 1 : (err_frame ? 2 : 3);
        chk("evt_onehot", 32'(err_parity) + 32'(err_frame) + 32'(overflow), 1);
        if (exp_evt.size() == 0) chk("evt_unexpected", ev, 0);
        else chk("evt", ev, exp_evt.pop_front());
      end
      if (code_valid) begin
        if (exp_q.size() == 0) chk("code_unexpected", {code_break, code_ext, code_byte}, 0);
        else begin
          chk("head", {code_break, code_ext, code_byte}, exp_q[0]);
          if (code_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] b;
    cyc(3);
    chk("reset_outs", {code_valid, code_byte, code_ext, code_break, err_parity, err_frame, overflow}, 0);
    rst_n = 1'b1;
    cyc(10);

    good(8'h1C);                                    // 1
    good(8'hF0); good(8'h1C);                       // 2
    good(8'hE0); good(8'hF0); good(8'h75);
    frame(8'h1C, 1'b1, 1'b1, 1'b0); good(8'h1C);    // 3

    model(8'h00, 1'b0, 1'b0);                       // 4: timeout abort
    send_bits({3'b000, 8'h05, 1'b0}, 4, 1'b0);
    w = 0;
    while (!err_frame && w < 3000) begin cyc(1); w++; end
    chk("timeout_seen", err_frame, 1);
    chk("timeout_delay_ok", 32'((cyc_cnt - last_fall) >= TO && (cyc_cnt - last_fall) <= TO + 12), 1);
    cyc(10);
    good(8'h29);
    frame(8'h1C, 1'b0, 1'b0, 1'b0);

    code_ready = 1'b0;                              // 5: backpressure / overflow
    good(8'h16); good(8'h1E); good(8'h26); good(8'h25); good(8'h2E);
    chk("bp_valid", code_valid, 1);
    chk("bp_head", {code_break, code_ext, code_byte}, 10'h016);
    code_ready = 1'b1;
    cyc(20);
    chk("drained_valid", code_valid, 0);
    chk("drained_q", exp_q.size(), 0);

    glitch(); cyc(20);                              // 6: glitches, reset mid-frame
    frame(8'h3A, ~^8'h3A, 1'b1, 1'b1);
    good(8'hF0);
    send_bits({3'b111, 8'h1C, 1'b0}, 5, 1'b0);
    rst_n = 1'b0; m_ext = 0; m_brk = 0;
    cyc(2);
    chk("midreset_outs", {code_valid, code_byte, code_ext, code_break, err_parity, err_frame, overflow}, 0);
    rst_n = 1'b1;
    cyc(10);
    good(8'h1C);

    for (int i = 0; i < 10; i++) begin             // randomized frames
      int r;
      r = $urandom_range(0, 3);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      frame(b, ($urandom_range(0, 7) == 0) ? ^b : ~^b,
            $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
    end

    cyc(300);
    chk("end_codes_q", exp_q.size(), 0);
    chk("end_evt_q", exp_evt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
